// File: rtl/hps_instr_responder.sv
// hps_instr_responder: FPGA-side endpoint of the HPS PIO instruction channel.
// Decodes a strobed 29-bit instruction into a pixel write, a pixel read, an
// engine start or a dataout clear, and reports results through dataout/flags.
//
// Ports:
//   clk_clk, reset_reset      : clock, synchronous active-high reset
//   instruct[28:0], enable    : instruction word {rsvd, wdata[7:0], addr[16:0], op[2:0]}
//                               and launch strobe (rising edge launches)
//   dataout[7:0], flags[3:0]  : last read pixel; {ENG_ACTIVE, BUSY, ERROR, DONE}
//   mem_addr/wdata/we, mem_rdata : image RAM port (read data one cycle after address)
//   eng_start/mode, eng_done  : processing engine handshake
module hps_instr_responder #(
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned MEM_DEPTH      = 76800,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [28:0]       instruct,
  input  logic              enable,
  output logic [7:0]        dataout,
  output logic [3:0]        flags,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              eng_start,
  output logic [2:0]        eng_mode,
  input  logic              eng_done
);

  // Wide enough to hold TIMEOUT_CYCLES-1 for any parameter value.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WRITE,
    S_READ_WAIT,
    S_READ_CAP,
    S_ENG_WAIT,
    S_COMPLETE
  } state_t;

  state_t            state_q, state_d;
  logic              en_q;
  logic [27:0]       instr_q, instr_d;
  logic [7:0]        dataout_q, dataout_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              eng_start_q, eng_start_d;
  logic [2:0]        eng_mode_q, eng_mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       launch;
  logic [2:0] op;
  logic       addr_bad;
  logic       unused_reserved;

  // Bit 28 of the instruction word is reserved and intentionally ignored.
  assign unused_reserved = instruct[28];

  assign launch   = enable & ~en_q;
  assign op       = instr_q[2:0];
  assign addr_bad = (32'(instr_q[19:3]) >= MEM_DEPTH);

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    dataout_d   = dataout_q;
    done_d      = done_q;
    error_d     = error_q;
    busy_d      = busy_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;       // single-cycle strobes fall back to 0
    eng_start_d = 1'b0;
    eng_mode_d  = eng_mode_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          instr_d = instruct[27:0];
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (op)
          OP_NOP: state_d = S_COMPLETE;
          OP_CLEAR: begin
            dataout_d = 8'h00;
            state_d   = S_COMPLETE;
          end
          OP_STORE, OP_LOAD: begin
            if (addr_bad) begin
              // Out-of-range address: flag it and never touch the RAM.
              error_d = 1'b1;
              state_d = S_COMPLETE;
            end else begin
              mem_addr_d = ADDR_W'(instr_q[19:3]);
              if (op == OP_STORE) begin
                mem_wdata_d = instr_q[27:20];
                mem_we_d    = 1'b1;
                state_d     = S_WRITE;
              end else begin
                state_d = S_READ_WAIT;
              end
            end
          end
          default: begin
            // 011..110 select the engine algorithm directly.
            eng_start_d = 1'b1;
            eng_mode_d  = op;
            cnt_d       = '0;
            state_d     = S_ENG_WAIT;
          end
        endcase
      end

      S_WRITE:     state_d = S_COMPLETE;

      S_READ_WAIT: state_d = S_READ_CAP;

      S_READ_CAP: begin
        dataout_d = mem_rdata;
        state_d   = S_COMPLETE;
      end

      S_ENG_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // eng_done wins over a timeout landing in the same cycle.
        if (eng_done) begin
          state_d = S_COMPLETE;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          state_d = S_COMPLETE;
        end
      end

      S_COMPLETE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A launch outside IDLE is dropped but reported; the running op carries on.
    if (launch && (state_q != S_IDLE)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b1;    // enable held high through reset must not launch
      instr_q     <= '0;
      dataout_q   <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      eng_start_q <= 1'b0;
      eng_mode_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= enable;
      instr_q     <= instr_d;
      dataout_q   <= dataout_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      eng_start_q <= eng_start_d;
      eng_mode_q  <= eng_mode_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dataout   = dataout_q;
  assign flags     = {(state_q == S_ENG_WAIT), busy_q, error_q, done_q};
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign eng_start = eng_start_q;
  assign eng_mode  = eng_mode_q;

endmodule

// File: tb/tb_hps_instr_responder.sv
// tb_hps_instr_responder: directed-vector bench for hps_instr_responder.
// Main instance uses default parameters with a behavioural RAM; a second
// instance with TIMEOUT_CYCLES=16 covers the engine timeout boundary.
module tb_hps_instr_responder;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [28:0] instruct = '0;
  logic        enable = 1'b0;
  logic        enable_to = 1'b0;
  logic        eng_done = 1'b0;

  logic [7:0]  dataout;
  logic [3:0]  flags;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        eng_start;
  logic [2:0]  eng_mode;

  logic [7:0]  unused_to_dataout;
  logic [3:0]  to_flags;
  logic [16:0] unused_to_addr;
  logic [7:0]  unused_to_wdata;
  logic        unused_to_we;
  logic        to_eng_start;
  logic [2:0]  to_eng_mode;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int start_cnt = 0;
  int to_start_cnt = 0;

  logic [7:0] ram [0:76799];

  always #5 clk_clk = ~clk_clk;

  hps_instr_responder dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .instruct   (instruct),
    .enable     (enable),
    .dataout    (dataout),
    .flags      (flags),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .eng_start  (eng_start),
    .eng_mode   (eng_mode),
    .eng_done   (eng_done)
  );

  hps_instr_responder #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .instruct   (instruct),
    .enable     (enable_to),
    .dataout    (unused_to_dataout),
    .flags      (to_flags),
    .mem_addr   (unused_to_addr),
    .mem_wdata  (unused_to_wdata),
    .mem_we     (unused_to_we),
    .mem_rdata  (8'h00),
    .eng_start  (to_eng_start),
    .eng_mode   (to_eng_mode),
    .eng_done   (eng_done)
  );

  // Synchronous-read RAM: data for an address appears one cycle later.
  always @(posedge clk_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk_clk) begin
    if (mem_we)       we_cnt++;
    if (eng_start)    start_cnt++;
    if (to_eng_start) to_start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // Present an instruction with a rising enable; returns just after E0.
  task automatic launch(input logic [2:0] op, input logic [16:0] addr,
                        input logic [7:0] d, input bit to_inst);
    instruct = {1'b0, d, addr, op};
    if (to_inst) enable_to = 1'b1; else enable = 1'b1;
    step();
    enable    = 1'b0;
    enable_to = 1'b0;
  endtask

  initial begin
    int w0;
    int s0;
    for (int i = 0; i < 76800; i++) ram[i] = 8'h00;

    // ---- reset state ----
    repeat (3) step();
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_dataout", 32'(dataout), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_eng_start", 32'(eng_start), 32'h0);
    chk("rst_eng_mode", 32'(eng_mode), 32'h0);
    reset_reset = 1'b0;
    step();

    // ---- STORE 0xA7 to address 5 ----
    w0 = we_cnt;
    launch(3'b001, 17'd5, 8'hA7, 1'b0);
    chk("st_busy_E0", 32'(flags), 32'b0100);
    step();
    chk("st_we_E1", 32'(mem_we), 32'h1);
    chk("st_addr_E1", 32'(mem_addr), 32'd5);
    chk("st_wdata_E1", 32'(mem_wdata), 32'hA7);
    step();
    chk("st_we_E2", 32'(mem_we), 32'h0);
    chk("st_flags_E2", 32'(flags), 32'b0100);
    step();
    chk("st_flags_E3", 32'(flags), 32'b0001);
    chk("st_we_count", 32'(we_cnt - w0), 32'd1);

    // ---- LOAD address 5 ----
    launch(3'b010, 17'd5, 8'h00, 1'b0);
    step();
    chk("ld_addr_E1", 32'(mem_addr), 32'd5);
    step();
    chk("ld_dout_E2", 32'(dataout), 32'h0);
    step();
    chk("ld_dout_E3", 32'(dataout), 32'hA7);
    chk("ld_flags_E3", 32'(flags), 32'b0100);
    step();
    chk("ld_flags_E4", 32'(flags), 32'b0001);

    // ---- range checks: first invalid address, and the top of the field ----
    w0 = we_cnt;
    launch(3'b010, 17'd76800, 8'h00, 1'b0);
    step();
    chk("rng_ld_E1", 32'(flags), 32'b0110);
    step();
    chk("rng_ld_E2", 32'(flags), 32'b0011);
    chk("rng_ld_dout", 32'(dataout), 32'hA7);
    chk("rng_ld_addr", 32'(mem_addr), 32'd5);
    launch(3'b001, 17'h1FFFF, 8'h55, 1'b0);
    step();
    step();
    chk("rng_st_flags", 32'(flags), 32'b0011);
    chk("rng_st_no_we", 32'(we_cnt - w0), 32'd0);
    // highest valid address is accepted
    launch(3'b001, 17'd76799, 8'h11, 1'b0);
    step();
    chk("rng_top_we", 32'(mem_we), 32'h1);
    step();
    step();
    chk("rng_top_flags", 32'(flags), 32'b0001);

    // ---- eng_done while idle is ignored ----
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();
    chk("idle_done_ign", 32'(flags), 32'b0001);

    // ---- engine, opcode 100, done after 50 cycles ----
    s0 = start_cnt;
    launch(3'b100, 17'd0, 8'h00, 1'b0);
    step();
    chk("eng_start_E1", 32'(eng_start), 32'h1);
    chk("eng_mode_E1", 32'(eng_mode), 32'd4);
    chk("eng_flags_E1", 32'(flags), 32'b1100);
    step();
    chk("eng_start_E2", 32'(eng_start), 32'h0);
    repeat (47) step();
    chk("eng_flags_wait", 32'(flags), 32'b1100);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("eng_flags_Ek", 32'(flags), 32'b0100);
    step();
    chk("eng_flags_done", 32'(flags), 32'b0001);
    chk("eng_start_cnt", 32'(start_cnt - s0), 32'd1);
    chk("eng_mode_held", 32'(eng_mode), 32'd4);

    // ---- timeout instance: 16 wait cycles without eng_done ----
    launch(3'b011, 17'd0, 8'h00, 1'b1);
    step();
    chk("to_flags_E1", 32'(to_flags), 32'b1100);
    chk("to_mode", 32'(to_eng_mode), 32'd3);
    repeat (15) step();
    chk("to_flags_E16", 32'(to_flags), 32'b1100);
    step();
    chk("to_flags_E17", 32'(to_flags), 32'b0110);
    step();
    chk("to_flags_E18", 32'(to_flags), 32'b0011);
    chk("to_start_cnt", 32'(to_start_cnt), 32'd1);

    // eng_done coincident with the last wait cycle counts as success
    launch(3'b101, 17'd0, 8'h00, 1'b1);
    repeat (16) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("to_tie_E17", 32'(to_flags), 32'b0100);
    step();
    chk("to_tie_E18", 32'(to_flags), 32'b0001);

    // ---- launch while busy ----
    s0 = start_cnt;
    w0 = we_cnt;
    launch(3'b110, 17'd0, 8'h00, 1'b0);
    step();
    step();
    launch(3'b001, 17'd7, 8'h99, 1'b0);
    chk("busy_err_now", 32'(flags), 32'b1110);
    step();
    step();
    chk("busy_no_restart", 32'(start_cnt - s0), 32'd1);
    chk("busy_mode", 32'(eng_mode), 32'd6);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    step();
    chk("busy_final", 32'(flags), 32'b0011);
    chk("busy_no_we", 32'(we_cnt - w0), 32'd0);

    // ---- LOAD 0x3C, then CLEAR ----
    launch(3'b001, 17'd9, 8'h3C, 1'b0);
    repeat (3) step();
    launch(3'b010, 17'd9, 8'h00, 1'b0);
    repeat (4) step();
    chk("clr_pre_dout", 32'(dataout), 32'h3C);
    launch(3'b111, 17'd0, 8'h00, 1'b0);
    chk("clr_flags_E0", 32'(flags), 32'b0100);
    step();
    step();
    chk("clr_dout", 32'(dataout), 32'h00);
    chk("clr_flags", 32'(flags), 32'b0001);

    // ---- enable held high across reset release ----
    enable = 1'b1;
    reset_reset = 1'b1;
    repeat (2) step();
    reset_reset = 1'b0;
    repeat (3) step();
    chk("hold_en_flags", 32'(flags), 32'b0000);
    enable = 1'b0;
    step();

    // ---- reset asserted in READ_WAIT ----
    launch(3'b010, 17'd5, 8'h00, 1'b0);
    step();
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    repeat (3) step();
    chk("rrst_dout", 32'(dataout), 32'h00);
    chk("rrst_flags", 32'(flags), 32'b0000);
    launch(3'b000, 17'd0, 8'h00, 1'b0);
    step();
    step();
    chk("rrst_nop_flags", 32'(flags), 32'b0001);

    // ---- reset during DECODE of a STORE issues no write ----
    w0 = we_cnt;
    launch(3'b001, 17'd3, 8'h44, 1'b0);
    reset_reset = 1'b1;
    step();
    chk("srst_we", 32'(mem_we), 32'h0);
    reset_reset = 1'b0;
    repeat (3) step();
    chk("srst_we_cnt", 32'(we_cnt - w0), 32'd0);
    chk("srst_flags", 32'(flags), 32'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
